// File: rtl/ofm_writeback_pkg.sv
// ofm_writeback_pkg: shared widths, FSM encodings and the requantisation helper.
package ofm_writeback_pkg;
    localparam int IN_W       = 25;
    localparam int PACK       = 8;
    localparam int OUT_W      = 8 * PACK;
    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_AW    = 2;
    localparam int QNT_W      = 26;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Round half up, arithmetic shift, then saturate to the selected int8/uint8 range.
    function automatic logic [7:0] quant(input logic signed [IN_W-1:0] s, input logic [4:0] sh,
                                         input logic relu);
        logic signed [QNT_W-1:0] x, rnd, y;
        x   = s;
        rnd = (sh != 5'd0) ? QNT_W'(1) << (sh - 5'd1) : '0;
        y   = (x + rnd) >>> sh;
        return relu ? (y < 0 ? 8'h00 : y > 255 ? 8'hFF : y[7:0])
                    : (y < -128 ? 8'h80 : y > 127 ? 8'h7F : y[7:0]);
    endfunction
endpackage

// File: rtl/ofm_writeback_if.sv
// ofm_writeback_if: valid/ready word port towards the memory write master.
interface ofm_writeback_if import ofm_writeback_pkg::*; ();
    logic [OUT_W-1:0] data;
    logic             lane;
    logic             valid;
    logic             ready;

    modport master (output data, lane, valid, input ready);
    modport slave  (input data, lane, valid, output ready);
endinterface

// File: rtl/ofm_writeback_fifo.sv
// ofm_writeback_fifo: first-word fall-through word FIFO; pushes into a full FIFO are dropped.
module ofm_writeback_fifo import ofm_writeback_pkg::*; (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [OUT_W-1:0] din,
    output logic [OUT_W-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int CW = FIFO_AW + 1;

    logic [OUT_W-1:0]   mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wp, rp;
    logic [CW-1:0]      cnt;
    logic               wr, rd;

    assign full  = cnt == CW'(FIFO_DEPTH);
    assign empty = cnt == '0;
    assign wr    = push && !full;
    assign rd    = pop && !empty;
    assign dout  = mem[rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            wp  <= clr ? '0 : wp + FIFO_AW'(wr);
            rp  <= clr ? '0 : rp + FIFO_AW'(rd);
            cnt <= clr ? '0 : cnt + CW'(wr) - CW'(rd);
        end
    end

    always_ff @(posedge clk)
        if (wr) mem[wp] <= din;
endmodule

// File: rtl/ofm_writeback.sv
// ofm_writeback: requantises both CONV_ACC OFM lanes to int8, packs 8 bytes per word and
// drains the per-lane FIFOs over one valid/ready port; CONV_ACC is never stalled.
module ofm_writeback import ofm_writeback_pkg::*; (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_conv,
    input  logic            end_conv,
    input  logic [4:0]      cfg_shift,
    input  logic            cfg_relu,
    input  logic [IN_W-1:0] ofm_port0,
    input  logic [IN_W-1:0] ofm_port1,
    input  logic            ofm_port0_v,
    input  logic            ofm_port1_v,
    ofm_writeback_if.master wb,
    output logic            overflow,
    output logic            done
);
    logic [1:0]                 state, fcnt;
    logic                       flushed, flush_now, run;
    logic [1:0]                 in_v, q_v, push, pop, full, empty;
    logic [1:0][IN_W-1:0]       in_s;
    logic [1:0][7:0]            q_b;
    logic [1:0][2:0]            cnt;
    logic [1:0][OUT_W-1:0]      pbuf, nxt, dout;
    logic                       sel, ptr, lock_v, lock_lane, valid;

    assign run       = state == S_RUN || state == S_FLUSH;
    assign flush_now = state == S_FLUSH && fcnt == 2'd2 && !flushed;
    assign done      = state == S_DONE;

    // Capture register isolates CONV_ACC timing; quant runs on the captured sample.
    always_ff @(posedge clk) begin
        in_s <= {ofm_port1, ofm_port0};
        q_b  <= {quant(in_s[1], cfg_shift, cfg_relu), quant(in_s[0], cfg_shift, cfg_relu)};
    end

    always_comb begin
        nxt  = pbuf;
        push = '0;
        for (int l = 0; l < 2; l++) begin
            if (q_v[l]) nxt[l][{cnt[l], 3'b000} +: 8] = q_b[l];
            push[l] = (q_v[l] && cnt[l] == 3'd7) || (flush_now && (cnt[l] != 3'd0 || q_v[l]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            fcnt      <= '0;
            flushed   <= 1'b0;
            in_v      <= '0;
            q_v       <= '0;
            cnt       <= '0;
            pbuf      <= '0;
            overflow  <= 1'b0;
            ptr       <= 1'b0;
            lock_v    <= 1'b0;
            lock_lane <= 1'b0;
        end else begin
            state     <= start_conv ? S_RUN
                       : (state == S_RUN && end_conv) ? S_FLUSH
                       : (state == S_FLUSH && flushed && &empty) ? S_DONE : state;
            fcnt      <= start_conv ? 2'd0 : (state == S_FLUSH && fcnt != 2'd2) ? fcnt + 2'd1 : fcnt;
            flushed   <= !start_conv && (flushed || flush_now);
            in_v      <= start_conv ? 2'b00 : {ofm_port1_v, ofm_port0_v} & {2{run}};
            q_v       <= start_conv ? 2'b00 : in_v;
            overflow  <= !start_conv && (overflow || |(push & full));
            ptr       <= start_conv ? 1'b0 : (valid && wb.ready) ? !sel : ptr;
            lock_v    <= !start_conv && valid && !wb.ready;
            lock_lane <= !start_conv && sel;
            for (int l = 0; l < 2; l++) begin
                cnt[l]  <= (start_conv || push[l]) ? 3'd0 : q_v[l] ? cnt[l] + 3'd1 : cnt[l];
                pbuf[l] <= (start_conv || push[l]) ? '0 : nxt[l];
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_lane
        ofm_writeback_fifo u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (start_conv),
            .push  (push[g]),
            .pop   (pop[g]),
            .din   (nxt[g]),
            .dout  (dout[g]),
            .full  (full[g]),
            .empty (empty[g])
        );
    end

    // A stalled word keeps its lane locked so data/lane cannot change under the master.
    assign valid    = !(&empty);
    assign sel      = lock_v ? lock_lane : empty[0] ? 1'b1 : empty[1] ? 1'b0 : ptr;
    assign pop      = {2{valid && wb.ready}} & {sel, !sel};
    assign wb.valid = valid;
    assign wb.lane  = valid && sel;
    assign wb.data  = valid ? dout[sel] : '0;
endmodule

// File: tb/tb_ofm_writeback.sv
// tb_ofm_writeback: directed scenarios with a reference quant/pack model feeding a word scoreboard.
module tb_ofm_writeback;
    import ofm_writeback_pkg::*;

    logic            clk = 1'b0, rst_n = 1'b0, start_conv = 1'b0, end_conv = 1'b0;
    logic [4:0]      cfg_shift = '0;
    logic            cfg_relu = 1'b0;
    logic [IN_W-1:0] ofm_port0 = '0, ofm_port1 = '0;
    logic            ofm_port0_v = 1'b0, ofm_port1_v = 1'b0;
    logic            overflow, done;

    ofm_writeback_if wb ();

    ofm_writeback dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_conv  (start_conv),
        .end_conv    (end_conv),
        .cfg_shift   (cfg_shift),
        .cfg_relu    (cfg_relu),
        .ofm_port0   (ofm_port0),
        .ofm_port1   (ofm_port1),
        .ofm_port0_v (ofm_port0_v),
        .ofm_port1_v (ofm_port1_v),
        .wb          (wb),
        .overflow    (overflow),
        .done        (done)
    );

    always #5 clk = ~clk;

    int          checks = 0, passes = 0, fails = 0;
    logic [64:0] sb[$];
    logic [63:0] mw[2];
    int          mc[2];
    bit          active = 1'b0;

    task automatic chk(string tag, logic [64:0] obs, logic [64:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference requant: floor division of the rounded value, then clamp.
    function automatic logic [7:0] mq(int s, int sh, bit relu);
        longint x = s;
        longint d = longint'(1) << sh;
        longint y;
        if (sh > 0) x = x + d / 2;
        y = (x >= 0) ? x / d : -((-x + d - 1) / d);
        if (relu) y = (y < 0) ? 0 : (y > 255) ? 255 : y;
        else      y = (y < -128) ? -128 : (y > 127) ? 127 : y;
        return y[7:0];
    endfunction

    task automatic emit(int l);
        int n = 0;
        foreach (sb[i]) if (sb[i][64] == 1'(l)) n++;
        if (n < FIFO_DEPTH) sb.push_back({1'(l), mw[l]});
        mw[l] = '0;
        mc[l] = 0;
    endtask

    task automatic model(int l, int s);
        if (!active) return;
        mw[l][mc[l]*8 +: 8] = mq(s, int'(cfg_shift), cfg_relu);
        mc[l]++;
        if (mc[l] == PACK) emit(l);
    endtask

    task automatic step(bit v0, int s0, bit v1, int s1);
        ofm_port0   = s0[IN_W-1:0];
        ofm_port1   = s1[IN_W-1:0];
        ofm_port0_v = v0;
        ofm_port1_v = v1;
        if (v0) model(0, s0);
        if (v1) model(1, s1);
        @(posedge clk); #1;
        ofm_port0_v = 1'b0;
        ofm_port1_v = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start();
        start_conv = 1'b1;
        @(posedge clk); #1;
        start_conv = 1'b0;
        active = 1'b1;
        mw = '{64'd0, 64'd0};
        mc = '{0, 0};
    endtask

    task automatic finish_conv();
        end_conv = 1'b1;
        @(posedge clk); #1;
        end_conv = 1'b0;
        for (int l = 0; l < 2; l++) if (mc[l] > 0) emit(l);
    endtask

    task automatic wait_drain(int n);
        for (int i = 0; i < n && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_pending", 65'(sb.size()), 65'd0);
    endtask

    // Every visible word must match the scoreboard head, including while stalled.
    always @(negedge clk) begin
        if (rst_n && wb.valid) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $error("FAIL unexpected_word: observed %h expected none", {wb.lane, wb.data});
            end else begin
                chk("wb_word", {wb.lane, wb.data}, sb[0]);
                if (wb.ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        wb.ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 65'(wb.valid), 65'd0);
        chk("rst_data", 65'(wb.data), 65'd0);
        chk("rst_lane", 65'(wb.lane), 65'd0);
        chk("rst_overflow", 65'(overflow), 65'd0);
        chk("rst_done", 65'(done), 65'd0);
        rst_n = 1'b1;
        idle(1);
        start();

        // Dual-lane packing with saturation; lanes served 0,1,0,1
        cfg_relu = 1'b0; cfg_shift = 5'd0;
        for (int i = 0; i < 16; i++) step(1'b1, i * 10 - 80, 1'b1, i * 40 - 300);
        wait_drain(30);

        // ReLU + shift 4, latency of the completing sample
        cfg_relu = 1'b1; cfg_shift = 5'd4;
        for (int i = 0; i < 8; i++) step(1'b1, i * 16, 1'b0, 0);
        idle(1);
        chk("latency_early", 65'(wb.valid), 65'd0);
        idle(1);
        chk("latency_valid", 65'(wb.valid), 65'd1);
        wait_drain(20);

        // Signed clamp, then rounding with shift 1
        cfg_relu = 1'b0; cfg_shift = 5'd0;
        step(1'b1, -200, 1'b0, 0); step(1'b1, 200, 1'b0, 0);
        step(1'b1, -1, 1'b0, 0);   step(1'b1, 127, 1'b0, 0);
        for (int i = 0; i < 4; i++) step(1'b1, 0, 1'b0, 0);
        wait_drain(20);
        cfg_shift = 5'd1;
        step(1'b1, 3, 1'b0, 0);   step(1'b1, -3, 1'b0, 0);
        step(1'b1, 5, 1'b0, 0);   step(1'b1, -5, 1'b0, 0);
        step(1'b1, 1, 1'b0, 0);   step(1'b1, -1, 1'b0, 0);
        step(1'b1, 255, 1'b0, 0); step(1'b1, -256, 1'b0, 0);
        wait_drain(20);

        // Overflow: five words into a stalled lane, fifth dropped
        wb.ready = 1'b0; cfg_shift = 5'd2;
        for (int i = 0; i < 40; i++) step(1'b1, i * 4, 1'b0, 0);
        idle(5);
        chk("ovf_set", 65'(overflow), 65'd1);
        chk("ovf_stall_valid", 65'(wb.valid), 65'd1);
        idle(3);
        wb.ready = 1'b1;
        wait_drain(30);
        idle(3);
        chk("ovf_no_fifth", 65'(wb.valid), 65'd0);

        // Partial word flush and done
        cfg_shift = 5'd0;
        step(1'b1, 10, 1'b0, 0); step(1'b1, -20, 1'b0, 0); step(1'b1, 30, 1'b0, 0);
        finish_conv();
        chk("done_early", 65'(done), 65'd0);
        for (int i = 0; i < 50 && done !== 1'b1; i++) @(posedge clk);
        #1;
        chk("done_set", 65'(done), 65'd1);
        chk("flush_drained", 65'(sb.size()), 65'd0);
        chk("ovf_sticky", 65'(overflow), 65'd1);
        active = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b1, i, 1'b0, 0);
        idle(6);
        chk("done_ignores", 65'(wb.valid), 65'd0);
        chk("done_hold", 65'(done), 65'd1);
        start();
        chk("start_clr_done", 65'(done), 65'd0);
        chk("start_clr_ovf", 65'(overflow), 65'd0);

        // Asynchronous reset with two words queued and a half-full packer
        wb.ready = 1'b0;
        for (int i = 0; i < 20; i++) step(1'b1, i + 1, 1'b0, 0);
        idle(4);
        chk("pre_rst_valid", 65'(wb.valid), 65'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 65'(wb.valid), 65'd0);
        sb.delete();
        active = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        chk("post_rst_done", 65'(done), 65'd0);
        chk("post_rst_ovf", 65'(overflow), 65'd0);
        chk("post_rst_valid", 65'(wb.valid), 65'd0);
        wb.ready = 1'b1;
        start();
        for (int i = 0; i < 8; i++) step(1'b1, 50 + i, 1'b0, 0);
        wait_drain(20);
        idle(3);
        chk("post_rst_clean", 65'(wb.valid), 65'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
